// File: rtl/timer_irq_ctrl.sv
// Machine timer (mtime/mtimecmp) with a one-trap-per-event interrupt sequencer.
// Optional build macro TIMER_PRESCALE_EN slows mtime to one tick per PRESCALE_DIV clocks.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_4000,
  parameter int          PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  input  logic        irq_ack,
  input  logic        is_mret,
  output logic        timer_irq
);

  typedef enum logic [1:0] {IDLE, PENDING, SERVICING} state_t;

  state_t      state;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        in_win;
  logic [1:0]  sel;
  logic        mtime_wr;
  logic        cmp_wr;
  logic        match;
  logic        tick;
  logic        unused_addr_bits;

  // Byte-lane bits carry no information: only full-word accesses exist.
  assign unused_addr_bits = ^addr[1:0];

  assign in_win   = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel      = addr[3:2];
  assign mtime_wr = wr_en && in_win && !sel[1];
  assign cmp_wr   = wr_en && in_win && sel[1];
  assign match    = (mtime >= mtimecmp);

`ifdef TIMER_PRESCALE_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE_DIV - 1);
  logic [15:0] pre_cnt;

  // Rewriting mtime restarts the tick period so the new value gets a full interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (mtime_wr || (pre_cnt == PRE_LAST)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  assign tick = (pre_cnt == PRE_LAST);
`else
  assign tick = 1'b1;
`endif

  // A bus write replaces one word and freezes the other; no increment that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
    end else if (mtime_wr) begin
      if (sel[0]) begin
        mtime[63:32] <= wdata;
      end else begin
        mtime[31:0] <= wdata;
      end
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= '1;
    end else if (cmp_wr) begin
      if (sel[0]) begin
        mtimecmp[63:32] <= wdata;
      end else begin
        mtimecmp[31:0] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      if (!in_win) begin
        rdata <= '0;
      end else begin
        unique case (sel)
          2'd0:    rdata <= mtime[31:0];
          2'd1:    rdata <= mtime[63:32];
          2'd2:    rdata <= mtimecmp[31:0];
          default: rdata <= mtimecmp[63:32];
        endcase
      end
    end
  end

  // Ack beats a simultaneous match-clearing write, so a taken trap is always serviced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer_irq <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (match) begin
            state     <= PENDING;
            timer_irq <= 1'b1;
          end
        end
        PENDING: begin
          if (irq_ack) begin
            state     <= SERVICING;
            timer_irq <= 1'b0;
          end else if (!match) begin
            state     <= IDLE;
            timer_irq <= 1'b0;
          end
        end
        SERVICING: begin
          if (is_mret) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          timer_irq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: a register-map vector table plus hand-written
// sequences for interrupt sequencing, carry/wrap and asynchronous reset.
module tb_timer_irq_ctrl;

`ifdef TIMER_PRESCALE_EN
  localparam int TICK = 4;
`else
  localparam int TICK = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rdata;
  logic        irq_ack = 1'b0;
  logic        is_mret = 1'b0;
  logic        timer_irq;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[16];

  timer_irq_ctrl #(
    .BASE_ADDR   (32'h0000_4000),
    .PRESCALE_DIV(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rdata    (rdata),
    .irq_ack  (irq_ack),
    .is_mret  (is_mret),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr  = a;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk(name, rdata, exp);
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    irq_ack = 1'b0;
    is_mret = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic idle_hi;

    tbl[0]  = '{1'b0, 1'b1, 32'h4008, 32'h0, 32'hFFFF_FFFF};
    tbl[1]  = '{1'b0, 1'b1, 32'h400C, 32'h0, 32'hFFFF_FFFF};
    tbl[2]  = '{1'b0, 1'b1, 32'h4004, 32'h0, 32'h0000_0000};
    tbl[3]  = '{1'b1, 1'b0, 32'h4008, 32'h1234_5678, 32'h0000_0000};
    tbl[4]  = '{1'b1, 1'b0, 32'h400C, 32'h9ABC_DEF0, 32'h0000_0000};
    tbl[5]  = '{1'b0, 1'b1, 32'h4008, 32'h0, 32'h1234_5678};
    tbl[6]  = '{1'b0, 1'b1, 32'h400C, 32'h0, 32'h9ABC_DEF0};
    tbl[7]  = '{1'b1, 1'b0, 32'h5008, 32'h0, 32'h9ABC_DEF0};
    tbl[8]  = '{1'b0, 1'b1, 32'h4008, 32'h0, 32'h1234_5678};
    tbl[9]  = '{1'b0, 1'b1, 32'h4010, 32'h0, 32'h0000_0000};
    tbl[10] = '{1'b0, 1'b1, 32'h3FFC, 32'h0, 32'h0000_0000};
    tbl[11] = '{1'b1, 1'b0, 32'h4004, 32'hDEAD_0001, 32'h0000_0000};
    tbl[12] = '{1'b0, 1'b1, 32'h4004, 32'h0, 32'hDEAD_0001};
    tbl[13] = '{1'b0, 1'b0, 32'h4000, 32'h0, 32'hDEAD_0001};
    tbl[14] = '{1'b1, 1'b0, 32'h400C, 32'h0, 32'hDEAD_0001};
    tbl[15] = '{1'b0, 1'b1, 32'h400C, 32'h0, 32'h0000_0000};

    // Reset values and 100-cycle idle count
    #2;
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset_dut();
    idle_hi = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (timer_irq !== 1'b0) idle_hi = 1'b1;
    end
    chk("idle_irq", {31'b0, idle_hi}, 32'h0);
    bus_rd("idle_mtime", 32'h4000, 32'(100 / TICK));

    // Register map table
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      addr  = tbl[i].addr;
      wdata = tbl[i].wdata;
      wr_en = tbl[i].wr;
      rd_en = tbl[i].rd;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk($sformatf("tbl[%0d]", i), rdata, tbl[i].exp_rdata);
    end

    // Raise, acknowledge, mret re-arm
    reset_dut();
    bus_wr(32'h400C, 32'd0);
    bus_wr(32'h4008, 32'd50);
    bus_wr(32'h4000, 32'd40);
    repeat (10 * TICK) step();
    chk("irq_early", {31'b0, timer_irq}, 32'h0);
    step();
    chk("irq_rise", {31'b0, timer_irq}, 32'h1);
    repeat (5) step();
    chk("irq_hold", {31'b0, timer_irq}, 32'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("ack_drop", {31'b0, timer_irq}, 32'h0);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    repeat (4) step();
    chk("svc_hold", {31'b0, timer_irq}, 32'h0);
    is_mret = 1'b1;
    step();
    is_mret = 1'b0;
    chk("mret_idle", {31'b0, timer_irq}, 32'h0);
    step();
    chk("mret_rearm", {31'b0, timer_irq}, 32'h1);
    is_mret = 1'b1;
    step();
    is_mret = 1'b0;
    step();
    chk("mret_ignored", {31'b0, timer_irq}, 32'h1);

    // Ack coinciding with a match-clearing write still enters SERVICING
    irq_ack = 1'b1;
    addr    = 32'h4008;
    wdata   = 32'hFFFF_FFFF;
    wr_en   = 1'b1;
    step();
    irq_ack = 1'b0;
    wr_en   = 1'b0;
    chk("race_ack", {31'b0, timer_irq}, 32'h0);
    bus_wr(32'h4008, 32'd50);
    repeat (3) step();
    chk("race_svc", {31'b0, timer_irq}, 32'h0);
    is_mret = 1'b1;
    step();
    is_mret = 1'b0;
    step();
    chk("race_rearm", {31'b0, timer_irq}, 32'h1);

    // Match cleared by a write while PENDING, no ack
    reset_dut();
    bus_wr(32'h400C, 32'd0);
    bus_wr(32'h4008, 32'd0);
    step();
    chk("pend_set", {31'b0, timer_irq}, 32'h1);
    bus_wr(32'h4008, 32'hFFFF_FFFF);
    chk("clr_lag", {31'b0, timer_irq}, 32'h1);
    step();
    chk("clr_drop", {31'b0, timer_irq}, 32'h0);
    repeat (3) step();
    chk("clr_idle", {31'b0, timer_irq}, 32'h0);

    // Low-to-high carry and full 64-bit wrap
    bus_wr(32'h4000, 32'hFFFF_FFFF);
    bus_wr(32'h4004, 32'h0);
    repeat (TICK) step();
    bus_rd("carry_lo", 32'h4000, 32'h0);
    bus_rd("carry_hi", 32'h4004, 32'h1);
    bus_wr(32'h4000, 32'hFFFF_FFFF);
    bus_wr(32'h4004, 32'hFFFF_FFFF);
    repeat (TICK) step();
    bus_rd("wrap_lo", 32'h4000, 32'h0);
    bus_rd("wrap_hi", 32'h4004, 32'h0);

    // Asynchronous reset mid-count
    bus_wr(32'h400C, 32'd0);
    bus_wr(32'h4008, 32'd0);
    bus_wr(32'h4004, 32'd5);
    bus_rd("pre_rst_rd", 32'h4004, 32'd5);
    chk("pre_rst_irq", {31'b0, timer_irq}, 32'h1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_irq", {31'b0, timer_irq}, 32'h0);
    chk("async_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus_rd("post_rst_lo", 32'h4000, 32'h0);
    bus_rd("post_rst_hi", 32'h4004, 32'h0);
    bus_rd("post_rst_cmp_lo", 32'h4008, 32'hFFFF_FFFF);
    bus_rd("post_rst_cmp_hi", 32'h400C, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
